// File: rtl/ir_carrier_timer_if.sv
// Controller <-> IR carrier/delay responder bundle.
// The controller drives the *_in signals and the timer drives the *_out signals.
interface ir_carrier_timer_if #(
    parameter int unsigned DELAY_BITS = 16,
    parameter int unsigned PWM_BITS   = 8
);
    logic                  delay_enable_in;
    logic                  delay_start_strobe_in;
    logic [DELAY_BITS-1:0] delay_value_in;
    logic                  delay_busy_out;
    logic                  pwm_enable_in;
    logic                  pwm_forced_in;
    logic                  pwm_wr_strobe_in;
    logic [PWM_BITS-1:0]   pwm_value_in;
    logic                  pwm_wr_ack_out;
    logic                  ir_out;

    modport master (
        output delay_enable_in, delay_start_strobe_in, delay_value_in,
        output pwm_enable_in, pwm_forced_in, pwm_wr_strobe_in, pwm_value_in,
        input  delay_busy_out, pwm_wr_ack_out, ir_out
    );

    modport slave (
        input  delay_enable_in, delay_start_strobe_in, delay_value_in,
        input  pwm_enable_in, pwm_forced_in, pwm_wr_strobe_in, pwm_value_in,
        output delay_busy_out, pwm_wr_ack_out, ir_out
    );
endinterface

// File: rtl/ir_carrier_timer.sv
// IR carrier generator and unit-based delay timer.
// The two engines are independent and share only clock and reset.
module ir_carrier_timer #(
    parameter int unsigned UNIT_COUNTS_US = 10,
    parameter int unsigned CLK_MHZ        = 8,
    parameter int unsigned DELAY_BITS     = 16,
    parameter int unsigned PWM_BITS       = 8
) (
    input logic                clock_in,
    input logic                reset_in,
    ir_carrier_timer_if.slave  bus
);
    localparam int unsigned UNIT_CLKS  = UNIT_COUNTS_US * CLK_MHZ;
    localparam int unsigned PRESC_BITS = $clog2(UNIT_CLKS);
    localparam logic [PRESC_BITS-1:0] PRESC_LAST = PRESC_BITS'(UNIT_CLKS - 1);

    localparam logic [0:0] D_IDLE = 1'b0;
    localparam logic [0:0] D_RUN  = 1'b1;

    logic [0:0]            dstate_q, dstate_d;
    logic [DELAY_BITS-1:0] units_q, units_d;
    logic [PRESC_BITS-1:0] presc_q, presc_d;
    logic                  busy_q, busy_d;
    logic                  armed_q, armed_d;

    logic [PWM_BITS-1:0]   active_q, active_d;
    logic [PWM_BITS-1:0]   pending_q, pending_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [PWM_BITS-1:0]   cnt_q, cnt_d;
    logic                  mod_q, mod_d;
    logic                  ir_q, ir_d;
    logic                  ack_q, ack_d;

    logic                  mod_c;
    logic                  running_c;
    logic                  boundary_c;

    // Delay engine: a held strobe must drop (re-arm) before another start is taken
    always_comb begin
        dstate_d = dstate_q;
        units_d  = units_q;
        presc_d  = presc_q;
        busy_d   = busy_q;
        armed_d  = armed_q;
        if (!bus.delay_start_strobe_in) armed_d = 1'b1;
        case (dstate_q)
            D_IDLE: begin
                busy_d = 1'b0;
                if (bus.delay_enable_in && bus.delay_start_strobe_in && armed_q) begin
                    dstate_d = D_RUN;
                    units_d  = bus.delay_value_in;
                    presc_d  = '0;
                    busy_d   = 1'b1;
                    armed_d  = 1'b0;
                end
            end
            D_RUN: begin
                if (!bus.delay_enable_in || (units_q == '0) ||
                    ((presc_q == PRESC_LAST) && (units_q == DELAY_BITS'(1)))) begin
                    dstate_d = D_IDLE;
                    units_d  = '0;
                    presc_d  = '0;
                    busy_d   = 1'b0;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    units_d = units_q - DELAY_BITS'(1);
                end else begin
                    presc_d = presc_q + PRESC_BITS'(1);
                end
            end
            default: dstate_d = D_IDLE;
        endcase
    end

    assign mod_c      = !bus.pwm_forced_in && bus.pwm_enable_in && (active_q != '0);
    assign running_c  = mod_c && mod_q;
    assign boundary_c = running_c && (cnt_q == (active_q - PWM_BITS'(1)));

    // Carrier engine: new values only take effect on a half-period boundary while modulating
    always_comb begin
        active_d     = active_q;
        pending_d    = pending_q;
        pend_valid_d = pend_valid_q;
        cnt_d        = cnt_q;
        ir_d         = ir_q;
        ack_d        = 1'b0;
        mod_d        = mod_c;

        if (running_c) begin
            if (boundary_c && (bus.pwm_wr_strobe_in || pend_valid_q)) begin
                active_d     = bus.pwm_wr_strobe_in ? bus.pwm_value_in : pending_q;
                pend_valid_d = 1'b0;
                ack_d        = 1'b1;
            end else if (bus.pwm_wr_strobe_in) begin
                pending_d    = bus.pwm_value_in;
                pend_valid_d = 1'b1;
            end
        end else if (bus.pwm_wr_strobe_in || pend_valid_q) begin
            active_d     = bus.pwm_wr_strobe_in ? bus.pwm_value_in : pending_q;
            pend_valid_d = 1'b0;
            ack_d        = 1'b1;
        end

        if (bus.pwm_forced_in) begin
            ir_d  = 1'b1;
            cnt_d = '0;
        end else if (mod_c) begin
            if (!mod_q) begin
                ir_d  = 1'b1;
                cnt_d = '0;
            end else if (boundary_c) begin
                ir_d  = !ir_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + PWM_BITS'(1);
            end
        end else begin
            ir_d  = 1'b0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            dstate_q     <= D_IDLE;
            units_q      <= '0;
            presc_q      <= '0;
            busy_q       <= 1'b0;
            armed_q      <= 1'b1;
            active_q     <= '0;
            pending_q    <= '0;
            pend_valid_q <= 1'b0;
            cnt_q        <= '0;
            mod_q        <= 1'b0;
            ir_q         <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            dstate_q     <= dstate_d;
            units_q      <= units_d;
            presc_q      <= presc_d;
            busy_q       <= busy_d;
            armed_q      <= armed_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            pend_valid_q <= pend_valid_d;
            cnt_q        <= cnt_d;
            mod_q        <= mod_d;
            ir_q         <= ir_d;
            ack_q        <= ack_d;
        end
    end

    assign bus.delay_busy_out = busy_q;
    assign bus.pwm_wr_ack_out = ack_q;
    assign bus.ir_out         = ir_q;
endmodule

// File: tb/tb_ir_carrier_timer.sv
// Directed bench for ir_carrier_timer: vector table plus multi-cycle sequences.
module tb_ir_carrier_timer;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    ir_carrier_timer_if #(.DELAY_BITS(16), .PWM_BITS(8)) bus ();

    ir_carrier_timer dut (
        .clock_in (clk),
        .reset_in (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        den;
        logic        dstb;
        logic [15:0] dval;
        logic        pen;
        logic        pfrc;
        logic        pwr;
        logic [7:0]  pval;
        logic        busy;
        logic        ack;
        logic        ir;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic den, input logic dstb, input int dval,
                       input logic pen, input logic pfrc, input logic pwr, input int pval,
                       input logic busy, input logic ack, input logic ir);
        vec_t v;
        v.rst = r; v.den = den; v.dstb = dstb; v.dval = 16'(dval);
        v.pen = pen; v.pfrc = pfrc; v.pwr = pwr; v.pval = 8'(pval);
        v.busy = busy; v.ack = ack; v.ir = ir;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.delay_enable_in       = 1'b0;
        bus.delay_start_strobe_in = 1'b0;
        bus.delay_value_in        = '0;
        bus.pwm_enable_in         = 1'b0;
        bus.pwm_forced_in         = 1'b0;
        bus.pwm_wr_strobe_in      = 1'b0;
        bus.pwm_value_in          = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        idle_inputs();

        //   rst den stb dval pen frc wr pval | busy ack ir
        add(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 4,  0, 1, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 1);
        add(0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 1);
        add(0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0,  1, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0,  1, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0,  0, 1, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst                       = tbl[i].rst;
            bus.delay_enable_in       = tbl[i].den;
            bus.delay_start_strobe_in = tbl[i].dstb;
            bus.delay_value_in        = tbl[i].dval;
            bus.pwm_enable_in         = tbl[i].pen;
            bus.pwm_forced_in         = tbl[i].pfrc;
            bus.pwm_wr_strobe_in      = tbl[i].pwr;
            bus.pwm_value_in          = tbl[i].pval;
            step();
            chk($sformatf("vec%0d_busy", i), int'(bus.delay_busy_out), int'(tbl[i].busy));
            chk($sformatf("vec%0d_ack", i),  int'(bus.pwm_wr_ack_out), int'(tbl[i].ack));
            chk($sformatf("vec%0d_ir", i),   int'(bus.ir_out),         int'(tbl[i].ir));
        end

        // value 3: busy one cycle after strobe, high for 3*80 cycles
        do_reset();
        bus.delay_enable_in       = 1'b1;
        bus.delay_value_in        = 16'd3;
        bus.delay_start_strobe_in = 1'b1;
        chk("d3_busy_before", int'(bus.delay_busy_out), 0);
        step();
        chk("d3_busy_rise", int'(bus.delay_busy_out), 1);
        bus.delay_start_strobe_in = 1'b0;
        cnt = 0;
        while (bus.delay_busy_out && cnt < 1000) begin
            cnt++;
            step();
        end
        chk("d3_busy_len", cnt, 240);

        // value 0 with strobe held: single busy cycle, no retrigger
        bus.delay_value_in        = 16'd0;
        bus.delay_start_strobe_in = 1'b1;
        step();
        chk("d0_busy_rise", int'(bus.delay_busy_out), 1);
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("d0_hold%0d", k), int'(bus.delay_busy_out), 0);
        end
        bus.delay_start_strobe_in = 1'b0;

        // value 100 aborted at cycle 500, then a fresh 1-unit delay
        do_reset();
        bus.delay_enable_in       = 1'b1;
        bus.delay_value_in        = 16'd100;
        bus.delay_start_strobe_in = 1'b1;
        step();
        bus.delay_start_strobe_in = 1'b0;
        for (int k = 1; k < 500; k++) step();
        chk("abort_busy_pre", int'(bus.delay_busy_out), 1);
        bus.delay_enable_in = 1'b0;
        step();
        chk("abort_busy_low", int'(bus.delay_busy_out), 0);
        bus.delay_enable_in       = 1'b1;
        bus.delay_value_in        = 16'd1;
        bus.delay_start_strobe_in = 1'b1;
        step();
        chk("restart_busy", int'(bus.delay_busy_out), 1);
        bus.delay_start_strobe_in = 1'b0;
        cnt = 0;
        while (bus.delay_busy_out && cnt < 1000) begin
            cnt++;
            step();
        end
        chk("restart_len", cnt, 80);

        // running at 4, write 6 mid half-period: ack at boundary, then 6-clock halves
        do_reset();
        bus.pwm_wr_strobe_in = 1'b1;
        bus.pwm_value_in     = 8'd4;
        step();
        bus.pwm_wr_strobe_in = 1'b0;
        bus.pwm_enable_in    = 1'b1;
        step();
        chk("m_entry_ir", int'(bus.ir_out), 1);
        step();
        step();
        bus.pwm_wr_strobe_in = 1'b1;
        bus.pwm_value_in     = 8'd6;
        step();
        bus.pwm_wr_strobe_in = 1'b0;
        chk("m_ack_early", int'(bus.pwm_wr_ack_out), 0);
        chk("m_ir_old_half", int'(bus.ir_out), 1);
        step();
        chk("m_ack_boundary", int'(bus.pwm_wr_ack_out), 1);
        for (int k = 0; k < 18; k++) begin
            if (k > 0) begin
                step();
                chk($sformatf("m_ack_after%0d", k), int'(bus.pwm_wr_ack_out), 0);
            end
            chk($sformatf("m_ir%0d", k), int'(bus.ir_out), (k >= 6 && k < 12) ? 1 : 0);
        end

        // forced steady-on, then reset mid-run with a pending write: no ack
        bus.pwm_forced_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("f_ir%0d", k), int'(bus.ir_out), 1);
        end
        bus.pwm_forced_in         = 1'b0;
        bus.delay_enable_in       = 1'b1;
        bus.delay_value_in        = 16'd5;
        bus.delay_start_strobe_in = 1'b1;
        step();
        bus.delay_start_strobe_in = 1'b0;
        step();
        bus.pwm_wr_strobe_in = 1'b1;
        bus.pwm_value_in     = 8'd9;
        step();
        bus.pwm_wr_strobe_in = 1'b0;
        chk("r_pre_busy", int'(bus.delay_busy_out), 1);
        chk("r_pre_ack", int'(bus.pwm_wr_ack_out), 0);
        rst = 1'b1;
        step();
        chk("r_busy", int'(bus.delay_busy_out), 0);
        chk("r_ack", int'(bus.pwm_wr_ack_out), 0);
        chk("r_ir", int'(bus.ir_out), 0);
        rst = 1'b0;
        step();
        chk("r_post_ack", int'(bus.pwm_wr_ack_out), 0);
        chk("r_post_ir", int'(bus.ir_out), 0);
        chk("r_post_busy", int'(bus.delay_busy_out), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
